alu_op_sequencer: RTL and testbench

//  Initiator-side controller for the 8-bit opermux ALU. Holds a short program of
//  (selector, operand) pairs, replays it on start and drives selector/data_in/enable.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_prog_mem.sv | 30 +++
 rtl/alu_op_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the opermux ALU and its op sequencer: selector codes
// and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_SHL  = 4'b0010;
  localparam logic [3:0] SEL_ASR  = 4'b0011;
  localparam logic [3:0] SEL_AND  = 4'b0100;
  localparam logic [3:0] SEL_OR   = 4'b0101;
  localparam logic [3:0] SEL_XOR  = 4'b0110;
  localparam logic [3:0] SEL_MOVB = 4'b1110;
  localparam logic [3:0] SEL_LOAD = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FINISH  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_prog_mem.sv
// Program store for the ALU op sequencer: DEPTH slots of {selector, operand},
// one synchronous write port, asynchronous read. Contents survive reset.
module alu_prog_mem #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [3:0]    wsel,
  input  logic [DW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [3:0]    rsel,
  output logic [DW-1:0] rdata
);

  logic [DW+3:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= {wsel, wdata};
    end
  end

  always_comb begin
    {rsel, rdata} = mem[raddr];
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator-side controller for the opermux ALU: stores a short op program,
// replays it on start and streams each captured ALU result.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2,
  parameter int DW     = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [3:0]    prog_sel,
  input  logic [DW-1:0] prog_data,
  input  logic          prog_clear,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          prog_full,
  output logic [PW:0]   prog_count,
  output logic [3:0]    alu_sel,
  output logic [DW-1:0] alu_data_in,
  output logic          alu_enable,
  input  logic [DW-1:0] alu_y,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic [PW-1:0] result_idx
);

  localparam int            SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [PW:0]   FULL_COUNT  = (PW + 1)'(DEPTH);

  seq_state_e    state_q, state_d;
  logic [PW:0]   count_q;
  logic [PW-1:0] rd_ptr_q;
  logic [SW-1:0] settle_q;
  logic [3:0]    slot_sel;
  logic [DW-1:0] slot_data;
  logic          at_last;
  logic          mem_we;
  logic          prog_ok, accept_start, do_issue, do_capture, do_finish;

  assign prog_full  = (count_q == FULL_COUNT);
  assign prog_count = count_q;
  assign at_last    = ({1'b0, rd_ptr_q} == count_q - (PW + 1)'(1));
  assign mem_we     = prog_ok && prog_we && !prog_clear && !prog_full && !reset;

  alu_prog_mem #(
    .DEPTH(DEPTH),
    .DW   (DW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(count_q[PW-1:0]),
    .wsel (prog_sel),
    .wdata(prog_data),
    .raddr(rd_ptr_q),
    .rsel (slot_sel),
    .rdata(slot_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (count_q != '0) ? ST_ISSUE : ST_FINISH;
        end
      end
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (settle_q == '0) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: state_d = at_last ? ST_FINISH : ST_ISSUE;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    prog_ok      = (state_q == ST_IDLE);
    accept_start = prog_ok && start;
    do_issue     = (state_q == ST_ISSUE);
    do_capture   = (state_q == ST_CAPTURE);
    do_finish    = (state_q == ST_FINISH);
  end

  // Strobes are registered one cycle behind the state that raises them, so the
  // ALU sees enable together with the freshly loaded selector/operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      settle_q     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      alu_enable   <= 1'b0;
      alu_sel      <= '0;
      alu_data_in  <= '0;
      result       <= '0;
      result_idx   <= '0;
    end else begin
      alu_enable   <= do_issue;
      result_valid <= do_capture;
      done         <= do_finish;

      if (prog_ok) begin
        if (prog_clear) begin
          count_q <= '0;
        end else if (prog_we && !prog_full) begin
          count_q <= count_q + (PW + 1)'(1);
        end
      end

      if (accept_start) begin
        busy     <= 1'b1;
        rd_ptr_q <= '0;
      end
      if (do_finish) begin
        busy <= 1'b0;
      end

      if (do_issue) begin
        alu_sel     <= slot_sel;
        alu_data_in <= slot_data;
        settle_q    <= SETTLE_LOAD;
      end else if (state_q == ST_WAIT && settle_q != '0) begin
        settle_q <= settle_q - SW'(1);
      end

      if (do_capture) begin
        result     <= alu_y;
        result_idx <= rd_ptr_q;
        if (!at_last) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer paired with a behavioural accumulator ALU;
// expected results are queued at start and popped as result_valid pulses arrive.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int DEPTH  = 16;
  localparam int SETTLE = 2;
  localparam int DW     = 8;
  localparam int PW     = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [3:0]    prog_sel = '0;
  logic [DW-1:0] prog_data = '0;
  logic          prog_clear = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, prog_full, alu_enable, result_valid;
  logic [PW:0]   prog_count;
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_data_in, alu_y, result;
  logic [PW-1:0] result_idx;

  alu_op_sequencer #(
    .DEPTH (DEPTH),
    .SETTLE(SETTLE),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_sel    (prog_sel),
    .prog_data   (prog_data),
    .prog_clear  (prog_clear),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .prog_full   (prog_full),
    .prog_count  (prog_count),
    .alu_sel     (alu_sel),
    .alu_data_in (alu_data_in),
    .alu_enable  (alu_enable),
    .alu_y       (alu_y),
    .result      (result),
    .result_valid(result_valid),
    .result_idx  (result_idx)
  );

  always #5 clk = ~clk;

  // Accumulator ALU: A is the visible result, B a scratch register.
  function automatic logic [15:0] alu_f(input logic [3:0] sel, input logic [7:0] d,
                                        input logic [7:0] a, input logic [7:0] b);
    logic [7:0] na;
    logic [7:0] nb;
    na = a;
    nb = b;
    case (sel)
      SEL_LOAD: na = d;
      SEL_MOVB: nb = a;
      SEL_ADD:  na = a + b;
      SEL_SUB:  na = a - b;
      SEL_ASR:  na = $unsigned($signed(a) >>> 1);
      default:  na = a;
    endcase
    return {na, nb};
  endfunction

  logic [7:0] ma, mb;
  assign alu_y = ma;

  always @(posedge clk) begin
    if (reset) begin
      ma <= '0;
      mb <= '0;
    end else if (alu_enable) begin
      {ma, mb} <= alu_f(alu_sel, alu_data_in, ma, mb);
    end
  end

  typedef struct {
    logic [3:0] idx;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] psel [DEPTH];
  logic [7:0] pdata[DEPTH];
  int         pcount = 0;
  logic [7:0] ra = '0;
  logic [7:0] rb = '0;
  int         checks = 0;
  int         errors = 0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] sel, input logic [7:0] data);
    prog_sel  = sel;
    prog_data = data;
    prog_we   = 1'b1;
    step();
    prog_we = 1'b0;
    if (pcount < DEPTH) begin
      psel[pcount]  = sel;
      pdata[pcount] = data;
      pcount++;
    end
  endtask

  task automatic clear_prog();
    prog_clear = 1'b1;
    step();
    prog_clear = 1'b0;
    pcount = 0;
  endtask

  // Replays the stored program; with disturb set, pokes start/prog_we/prog_clear mid-run.
  task automatic run(input bit disturb);
    int   cyc;
    int   last_en;
    int   n_en;
    int   n_done;
    int   n_extra;
    bit   seen_done;
    int   en_cyc[$];
    exp_t e;
    for (int i = 0; i < pcount; i++) begin
      {ra, rb} = alu_f(psel[i], pdata[i], ra, rb);
      sb.push_back('{idx: i[3:0], val: ra});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 0; last_en = -100; n_en = 0; n_done = 0; n_extra = 0; seen_done = 0;
    while (cyc < 200 && !seen_done) begin
      if (alu_enable) begin
        if (n_en > 0) chk("enable_gap", cyc - last_en, SETTLE + 2);
        if (n_en < pcount) begin
          chk("issue_sel", alu_sel, psel[n_en]);
          chk("issue_data", alu_data_in, pdata[n_en]);
        end else begin
          chk("extra_enable", n_en, pcount);
        end
        en_cyc.push_back(cyc);
        last_en = cyc;
        n_en++;
      end
      if (result_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.val);
          chk("result_idx", result_idx, e.idx);
          if (en_cyc.size() > 0) chk("latency", cyc - en_cyc.pop_front(), SETTLE + 1);
        end
      end
      if (done) begin
        seen_done = 1'b1;
        n_done++;
        chk("busy_at_done", busy, 0);
      end
      if (disturb) begin
        prog_we    = (cyc == 2);
        start      = (cyc == 2) || (cyc == 9);
        prog_clear = (cyc == 4);
        prog_sel   = SEL_LOAD;
        prog_data  = 8'h77;
      end
      step();
      cyc++;
    end
    prog_we = 1'b0; start = 1'b0; prog_clear = 1'b0;
    chk("done_seen", seen_done, 1);
    repeat (6) begin
      step();
      if (done) n_done++;
      if (result_valid || alu_enable || busy) n_extra++;
    end
    chk("done_once", n_done, 1);
    chk("no_activity_after_done", n_extra, 0);
    chk("enable_count", n_en, pcount);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_enable", alu_enable, 0);
    chk("rst_count", prog_count, 0);
    chk("rst_full", prog_full, 0);
    chk("rst_sel", alu_sel, 0);
    chk("rst_data", alu_data_in, 0);
    chk("rst_result", result, 0);
    chk("rst_idx", result_idx, 0);

    // Two loads
    load(SEL_LOAD, 8'h05);
    chk("count_1", prog_count, 1);
    load(SEL_LOAD, 8'h03);
    chk("count_2", prog_count, 2);
    run(1'b0);
    chk("p1_final", result, 8'h03);

    // Load, move to B, load, add; disturbances while busy must be ignored
    clear_prog();
    chk("count_cleared", prog_count, 0);
    load(SEL_LOAD, 8'h05);
    load(SEL_MOVB, 8'h00);
    load(SEL_LOAD, 8'h03);
    load(SEL_ADD,  8'hAA);
    run(1'b1);
    chk("p2_final", result, 8'h08);
    chk("p2_idx", result_idx, 3);
    chk("p2_count_kept", prog_count, 4);
    chk("p2_hold_sel", alu_sel, SEL_ADD);
    chk("p2_hold_data", alu_data_in, 8'hAA);

    // prog_clear wins over prog_we
    prog_sel = SEL_LOAD; prog_data = 8'h42;
    prog_we = 1'b1; prog_clear = 1'b1;
    step();
    prog_we = 1'b0; prog_clear = 1'b0;
    pcount = 0;
    chk("clear_wins", prog_count, 0);

    // Arithmetic shift of a negative value
    load(SEL_LOAD, 8'h80);
    load(SEL_ASR,  8'h00);
    run(1'b0);
    chk("p3_final", result, 8'hC0);
    chk("p3_idx", result_idx, 1);

    // Empty program
    clear_prog();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_busy", busy, 1);
    chk("empty_done_early", done, 0);
    chk("empty_enable_a", alu_enable, 0);
    step();
    chk("empty_busy_off", busy, 0);
    chk("empty_done", done, 1);
    chk("empty_enable_b", alu_enable, 0);
    step();
    chk("empty_done_pulse", done, 0);

    // Fill to capacity
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("not_full_15", prog_full, 0);
      load(SEL_LOAD, 8'(i * 7 + 1));
    end
    chk("full_flag", prog_full, 1);
    chk("full_count", prog_count, 16);
    load(SEL_LOAD, 8'hEE);
    chk("full_count_hold", prog_count, 16);
    chk("full_flag_hold", prog_full, 1);
    run(1'b0);
    chk("full_final", result, 8'(15 * 7 + 1));
    chk("full_idx", result_idx, 15);

    // Reset while waiting on the ALU
    clear_prog();
    load(SEL_LOAD, 8'h11);
    load(SEL_LOAD, 8'h22);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("pre_reset_enable", alu_enable, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    pcount = 0; ra = '0; rb = '0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_enable", alu_enable, 0);
    chk("mid_rst_count", prog_count, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", result_valid, 0);
    begin
      int stray;
      stray = 0;
      repeat (8) begin
        step();
        if (done || result_valid || alu_enable || busy) stray++;
      end
      chk("mid_rst_quiet", stray, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
